// File: rtl/mod_a_share_pkg.sv
// Shared types and helpers for the mod_a_share_arb round-robin unit arbiter.
package mod_a_share_pkg;

   typedef enum logic {IDLE, OWN} state_t;

   function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mod_a_share_arb_rr_pick.sv
// Round-robin priority search: first valid index at or after ptr, wrapping at N.
module rr_pick #(
   parameter int unsigned N   = 4,
   parameter int unsigned IDW = 2
) (
   input  logic [N-1:0]   valid,
   input  logic [IDW-1:0] ptr,
   output logic           found,
   output logic [IDW-1:0] idx
);

   logic [2*N-1:0] rot;
   int unsigned    s;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      s     = 0;
      // Doubled vector shifted by ptr puts the search start at bit 0.
      rot   = {valid, valid} >> ptr;
      for (int unsigned k = 0; k < N; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            s     = 32'(ptr) + k;
            if (s >= N) s = s - N;
            idx   = IDW'(s);
         end
      end
   end

endmodule

// File: rtl/mod_a_share_arb.sv
// Time-shares one combinational compute unit among N requesters with round-robin
// arbitration, a burst lock of up to BURST issues, and a back-pressured response slot.
module mod_a_share_arb
   import mod_a_share_pkg::*;
#(
   parameter  int unsigned N     = 4,
   parameter  int unsigned W     = 8,
   parameter  int unsigned BURST = 2,
   localparam int unsigned IDW   = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req_valid,
   output logic [N-1:0]   req_ready,
   input  logic [N*W-1:0] req_in1,
   input  logic [N*W-1:0] req_in2,
   output logic [W-1:0]   unit_in1,
   output logic [W-1:0]   unit_in2,
   input  logic [W-1:0]   unit_out,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [IDW-1:0] rsp_id,
   output logic [W-1:0]   rsp_data
);

   localparam int unsigned CW = $clog2(BURST + 1);

   state_t         state, state_n;
   logic [IDW-1:0] ptr, ptr_n, owner, owner_n, sel, pick_idx;
   logic [CW-1:0]  cnt, cnt_n;
   logic           pick_found, cand, can_issue, issue, owner_valid;

   rr_pick #(.N(N), .IDW(IDW)) u_pick (
      .valid (req_valid),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign sel  = (state == OWN) ? owner : pick_idx;
   assign cand = (state == OWN) || pick_found;
   // Gating with rst_n keeps every ready low for the whole reset interval.
   assign can_issue = rst_n && (!rsp_valid || rsp_ready);

   always_comb begin
      unit_in1    = '0;
      unit_in2    = '0;
      req_ready   = '0;
      owner_valid = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (cand && sel == IDW'(i)) begin
            unit_in1     = req_in1[i*W +: W];
            unit_in2     = req_in2[i*W +: W];
            req_ready[i] = req_valid[i] && can_issue;
         end
         if (owner == IDW'(i)) owner_valid = req_valid[i];
      end
      issue = |req_ready;
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      owner_n = owner;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (issue) begin
               if (BURST == 1) begin
                  ptr_n = IDW'(next_idx(32'(sel), N));
               end else begin
                  owner_n = sel;
                  cnt_n   = CW'(1);
                  state_n = OWN;
               end
            end
         end
         OWN: begin
            if (!owner_valid) begin
               ptr_n   = IDW'(next_idx(32'(owner), N));
               cnt_n   = '0;
               state_n = IDLE;
            end else if (issue) begin
               if (32'(cnt) + 1 == BURST) begin
                  ptr_n   = IDW'(next_idx(32'(owner), N));
                  cnt_n   = '0;
                  state_n = IDLE;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= '0;
         owner <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         owner <= owner_n;
         cnt   <= cnt_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else if (issue) begin
         rsp_valid <= 1'b1;
         rsp_id    <= sel;
         rsp_data  <= unit_out;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mod_a_share_arb.sv
// Bench for mod_a_share_arb: BURST=1 and BURST=2 instances share stimulus and are
// compared every cycle against a behavioural arbitration model.
module tb_mod_a_share_arb;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_in1, req_in2;
   logic           rsp_ready;

   logic [N-1:0] rdy   [2];
   logic [W-1:0] ui1   [2];
   logic [W-1:0] ui2   [2];
   logic [W-1:0] uo    [2];
   logic [W-1:0] rdata [2];
   logic         rv    [2];
   logic [1:0]   rid   [2];

   always #5 clk = ~clk;

   function automatic logic [W-1:0] unit_f(input logic [W-1:0] a, input logic [W-1:0] b);
      return (a ^ {b[3:0], b[7:4]}) + b;
   endfunction

   function automatic logic [W-1:0] opnd(input logic [N*W-1:0] v, input int i);
      return v[i*W +: W];
   endfunction

   assign uo[0] = unit_f(ui1[0], ui2[0]);
   assign uo[1] = unit_f(ui1[1], ui2[1]);

   mod_a_share_arb #(.N(N), .W(W), .BURST(1)) u_b1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]),
      .req_in1(req_in1), .req_in2(req_in2), .unit_in1(ui1[0]), .unit_in2(ui2[0]),
      .unit_out(uo[0]), .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_id(rid[0]),
      .rsp_data(rdata[0])
   );

   mod_a_share_arb #(.N(N), .W(W), .BURST(2)) u_b2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]),
      .req_in1(req_in1), .req_in2(req_in2), .unit_in1(ui1[1]), .unit_in2(ui2[1]),
      .unit_out(uo[1]), .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_id(rid[1]),
      .rsp_data(rdata[1])
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Model state per instance (0: BURST=1, 1: BURST=2)
   int           bst     [2] = '{1, 2};
   int           m_ptr   [2];
   int           m_owner [2];
   int           m_cnt   [2];
   int           m_rid   [2];
   bit           m_own   [2];
   bit           m_rv    [2];
   logic [W-1:0] m_rdata [2];
   int           g_exp   [2];
   logic [W-1:0] g_data  [2];
   logic [N-1:0] obs_rdy [2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_ptr[k] = 0; m_owner[k] = 0; m_cnt[k] = 0; m_rid[k] = 0;
         m_own[k] = 0; m_rv[k] = 0; m_rdata[k] = '0;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         int sel;
         bit cand;
         bit can;
         logic [N-1:0] er;
         logic [W-1:0] e1, e2;
         can  = !m_rv[k] || rsp_ready;
         cand = 0;
         sel  = 0;
         if (m_own[k]) begin
            cand = 1;
            sel  = m_owner[k];
         end else begin
            for (int j = 0; j < N; j++) begin
               int p;
               p = (m_ptr[k] + j) % N;
               if (!cand && req_valid[p]) begin
                  cand = 1;
                  sel  = p;
               end
            end
         end
         g_exp[k]  = (cand && req_valid[sel] && can) ? sel : -1;
         er        = (g_exp[k] >= 0) ? N'(1 << g_exp[k]) : '0;
         e1        = cand ? opnd(req_in1, sel) : '0;
         e2        = cand ? opnd(req_in2, sel) : '0;
         g_data[k] = unit_f(e1, e2);
         obs_rdy[k] = rdy[k];
         chk($sformatf("req_ready_b%0d", bst[k]), 32'(rdy[k]), 32'(er));
         chk($sformatf("unit_in1_b%0d", bst[k]), 32'(ui1[k]), 32'(e1));
         chk($sformatf("unit_in2_b%0d", bst[k]), 32'(ui2[k]), 32'(e2));
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         int g;
         g = g_exp[k];
         if (g >= 0) begin
            m_rv[k] = 1; m_rid[k] = g; m_rdata[k] = g_data[k];
         end else if (rsp_ready) begin
            m_rv[k] = 0;
         end
         if (!m_own[k]) begin
            if (g >= 0) begin
               if (bst[k] == 1) m_ptr[k] = (g + 1) % N;
               else begin m_own[k] = 1; m_owner[k] = g; m_cnt[k] = 1; end
            end
         end else if (!req_valid[m_owner[k]]) begin
            m_ptr[k] = (m_owner[k] + 1) % N; m_cnt[k] = 0; m_own[k] = 0;
         end else if (g >= 0) begin
            if (m_cnt[k] + 1 == bst[k]) begin
               m_ptr[k] = (m_owner[k] + 1) % N; m_cnt[k] = 0; m_own[k] = 0;
            end else m_cnt[k]++;
         end
         chk($sformatf("rsp_valid_b%0d", bst[k]), 32'(rv[k]), 32'(m_rv[k]));
         chk($sformatf("rsp_id_b%0d", bst[k]), 32'(rid[k]), 32'(m_rid[k]));
         chk($sformatf("rsp_data_b%0d", bst[k]), 32'(rdata[k]), 32'(m_rdata[k]));
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      model_reset();
      #2;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_rsp_valid_b%0d", bst[k]), 32'(rv[k]), 0);
         chk($sformatf("rst_req_ready_b%0d", bst[k]), 32'(rdy[k]), 0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic rand_ops();
      req_in1 = {$urandom, $urandom};
      req_in2 = {$urandom, $urandom};
   endtask

   typedef struct {
      logic [N-1:0] valid;
      logic         rr;
      logic [N-1:0] er_b1;
      logic [N-1:0] er_b2;
   } vec_t;

   vec_t tbl [13];

   initial begin
      tbl[0]  = '{4'b0101, 1'b1, 4'b0001, 4'b0001};
      tbl[1]  = '{4'b0101, 1'b1, 4'b0100, 4'b0001};
      tbl[2]  = '{4'b0101, 1'b1, 4'b0001, 4'b0100};
      tbl[3]  = '{4'b0101, 1'b1, 4'b0100, 4'b0100};
      tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001};
      tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 4'b0001};
      tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 4'b0010};
      tbl[7]  = '{4'b1111, 1'b1, 4'b1000, 4'b0010};
      tbl[8]  = '{4'b1111, 1'b1, 4'b0001, 4'b0100};
      tbl[9]  = '{4'b1111, 1'b1, 4'b0010, 4'b0100};
      tbl[10] = '{4'b1111, 1'b1, 4'b0100, 4'b1000};
      tbl[11] = '{4'b1111, 1'b1, 4'b1000, 4'b1000};
      tbl[12] = '{4'b1111, 1'b1, 4'b0001, 4'b0001};

      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      req_in1   = '0;
      req_in2   = '0;
      model_reset();
      #3;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("init_rsp_valid_b%0d", bst[k]), 32'(rv[k]), 0);
         chk($sformatf("init_rsp_id_b%0d", bst[k]), 32'(rid[k]), 0);
         chk($sformatf("init_rsp_data_b%0d", bst[k]), 32'(rdata[k]), 0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Alternating pair, then all-valid rotation from a fresh reset
      for (int i = 0; i < 13; i++) begin
         if (i == 4) do_reset();
         req_valid = tbl[i].valid;
         rsp_ready = tbl[i].rr;
         rand_ops();
         cycle();
         chk($sformatf("tbl%0d_b1", i), 32'(obs_rdy[0]), 32'(tbl[i].er_b1));
         chk($sformatf("tbl%0d_b2", i), 32'(obs_rdy[1]), 32'(tbl[i].er_b2));
      end

      // Owner drops valid inside a burst: bubble, then requester 2
      do_reset();
      req_valid = 4'b0110; rand_ops(); cycle();
      chk("own_first_b2", 32'(obs_rdy[1]), 32'h2);
      req_valid = 4'b0100; rand_ops(); cycle();
      chk("own_bubble_b2", 32'(obs_rdy[1]), 0);
      rand_ops(); cycle();
      chk("own_next_b2", 32'(obs_rdy[1]), 32'h4);

      // Response stall with requester 3 pending, then drain+refill
      do_reset();
      req_valid = 4'b1000; rsp_ready = 1'b1; rand_ops(); cycle();
      rsp_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         rand_ops(); cycle();
         chk("stall_ready_b1", 32'(obs_rdy[0]), 0);
         chk("stall_ready_b2", 32'(obs_rdy[1]), 0);
      end
      rsp_ready = 1'b1; rand_ops(); cycle();
      chk("refill_id_b1", 32'(rid[0]), 3);
      chk("refill_id_b2", 32'(rid[1]), 3);
      chk("refill_valid_b1", 32'(rv[0]), 1);

      // Wrap-around: lone requester 3 granted back to back
      do_reset();
      req_valid = 4'b1000; rand_ops(); cycle();
      chk("wrap_first_b1", 32'(obs_rdy[0]), 32'h8);
      rand_ops(); cycle();
      chk("wrap_again_b1", 32'(obs_rdy[0]), 32'h8);

      // Asynchronous reset in the middle of a burst
      do_reset();
      req_valid = 4'b1111; rand_ops(); cycle();
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_rsp_valid_b1", 32'(rv[0]), 0);
      chk("midrst_rsp_valid_b2", 32'(rv[1]), 0);
      chk("midrst_ready_b1", 32'(rdy[0]), 0);
      chk("midrst_ready_b2", 32'(rdy[1]), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req_valid = 4'b1010; rand_ops(); cycle();
      chk("postrst_grant_b1", 32'(obs_rdy[0]), 32'h2);
      chk("postrst_grant_b2", 32'(obs_rdy[1]), 32'h2);

      // Randomized traffic against the model
      do_reset();
      for (int c = 0; c < 400; c++) begin
         req_valid = N'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         rand_ops();
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
